// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - default widths, counter width and prefetch entry type for the fetch stage
package fetch_pkg;
  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_CNT_W    = $clog2(DEF_DEPTH) + 1;

  // Entry widths are fixed at the package defaults; fetch_unit must be built with matching widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] ins;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory request/response and decode handshake bundle
interface fetch_if import fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_ready;

  modport master (
    output imem_req, imem_addr, ins_valid, ins_data, ins_pc,
    input  imem_ready, imem_rvalid, imem_rdata, ins_ready
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins_data, ins_pc,
    output imem_ready, imem_rvalid, imem_rdata, ins_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, ins} entries; no bypass, flush empties it
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // When full, a push can only land in the slot being popped this same cycle.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr] <= push_entry;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !do_pop && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, credit-limited instruction fetch and redirect flush
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_if.master           bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  stale;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    committed;
  logic [DATA_W-1:0] rdata;
  logic              accept;
  logic              drop;
  logic              push;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Buffered plus outstanding words never exceed DEPTH, so responses always have a slot.
  assign committed    = {1'b0, count} + {1'b0, inflight};
  assign bus.imem_req  = !redirect_valid && (committed < (CNT_W+1)'(DEPTH));
  assign bus.imem_addr = pc;
  assign accept        = bus.imem_req && bus.imem_ready;

  assign drop  = redirect_valid || (stale != '0);
  assign push  = bus.imem_rvalid && !drop;
  assign pop   = bus.ins_valid && bus.ins_ready && !redirect_valid;
  assign rdata = bus.imem_rdata;

  // With no stale words pending, the oldest outstanding request sits inflight behind pc.
  assign push_entry.pc  = pc - ADDR_W'(inflight);
  assign push_entry.ins = rdata;

  assign bus.ins_valid = (count != '0);
  assign bus.ins_data  = head.ins;
  assign bus.ins_pc    = head.pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= ADDR_W'(RESET_PC);
      inflight <= '0;
      stale    <= '0;
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(bus.imem_rvalid);
      if (redirect_valid) begin
        pc    <= redirect_target;
        stale <= inflight - CNT_W'(bus.imem_rvalid);
      end else begin
        if (accept) pc <= pc + ADDR_W'(1);
        if (bus.imem_rvalid && stale != '0) stale <= stale - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> (inflight != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with an in-order fixed-latency memory model
module tb_fetch_unit;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       redirect_valid;
  logic [5:0] redirect_target;

  fetch_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  fetch_unit #(.ADDR_W(6), .DATA_W(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int mem_lat;
  int due_q[$];
  logic [5:0] addr_q[$];

  logic        o_req;
  logic [5:0]  o_addr;
  logic        o_valid;
  logic [5:0]  o_pc;
  logic [31:0] o_data;

  function automatic logic [31:0] word_at(logic [5:0] a);
    return 32'hA000_0000 + {26'b0, a};
  endfunction

  task automatic do_reset(int lat);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 6'd0;
    bus.imem_ready = 1'b1;
    bus.ins_ready = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    due_q.delete();
    addr_q.delete();
    mem_lat = lat;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive the memory response, snapshot DUT outputs, update the memory model.
  task automatic step();
    logic rv;
    rv = (due_q.size() != 0) && (due_q[0] <= cyc);
    bus.imem_rvalid = rv;
    bus.imem_rdata = rv ? word_at(addr_q[0]) : 32'h0;
    #1;
    o_req = bus.imem_req;
    o_addr = bus.imem_addr;
    o_valid = bus.ins_valid;
    o_pc = bus.ins_pc;
    o_data = bus.ins_data;
    if (rst_n) begin
      if (rv) begin
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
      if (o_req && bus.imem_ready) begin
        due_q.push_back(cyc + mem_lat);
        addr_q.push_back(o_addr);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(1);
    step();
    n_checks++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got %0b expected 1", o_req); end
    n_checks++; if (o_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d expected 0", o_addr); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b expected 0", o_valid); end
    bus.ins_ready = 1'b0;
    repeat (5) step();
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL prefill_valid got %0b expected 1", o_valid); end
    do_reset(1);
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %0b expected 0", o_valid); end
    n_checks++; if (o_req !== 1'b1 || o_addr !== 6'd0) begin n_fail++; $display("FAIL midreset_req got req=%0b addr=%0d expected req=1 addr=0", o_req, o_addr); end
  endtask

  task automatic test_stream();
    do_reset(1);
    for (int n = 0; n < 12; n++) begin
      step();
      if (n < 2) begin
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid cyc=%0d got %0b expected 0", n, o_valid); end
      end else begin
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'(n - 2)) begin n_fail++; $display("FAIL stream_pc cyc=%0d got valid=%0b pc=%0d expected valid=1 pc=%0d", n, o_valid, o_pc, n - 2); end
        n_checks++; if (o_data !== word_at(6'(n - 2))) begin n_fail++; $display("FAIL stream_data cyc=%0d got %h expected %h", n, o_data, word_at(6'(n - 2))); end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    do_reset(1);
    bus.ins_ready = 1'b0;
    accepts = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (o_req) accepts++;
    end
    n_checks++; if (accepts != 4) begin n_fail++; $display("FAIL bp_accepts got %0d expected 4", accepts); end
    step();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full got %0b expected 0", o_req); end
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd0) begin n_fail++; $display("FAIL bp_head got valid=%0b pc=%0d expected valid=1 pc=0", o_valid, o_pc); end
    bus.ins_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'(k) || o_data !== word_at(6'(k))) begin n_fail++; $display("FAIL bp_drain k=%0d got valid=%0b pc=%0d data=%h expected valid=1 pc=%0d", k, o_valid, o_pc, o_data, k); end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_target = 6'd40;
    step();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rdi_req_in_redirect got %0b expected 0", o_req); end
    redirect_valid = 1'b0;
    step();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 6'd40) begin n_fail++; $display("FAIL rdi_target_addr got req=%0b addr=%0d expected req=1 addr=40", o_req, o_addr); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_valid c3 got %0b expected 0", o_valid); end
    for (int n = 4; n < 7; n++) begin
      step();
      n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_stale_dropped cyc=%0d got valid=%0b pc=%0d expected valid=0", n, o_valid, o_pc); end
    end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd40 || o_data !== 32'hA000_0028) begin n_fail++; $display("FAIL rdi_first got valid=%0b pc=%0d data=%h expected valid=1 pc=40 data=a0000028", o_valid, o_pc, o_data); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd41) begin n_fail++; $display("FAIL rdi_second got valid=%0b pc=%0d expected valid=1 pc=41", o_valid, o_pc); end
  endtask

  task automatic test_redirect_pop();
    do_reset(1);
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_target = 6'd20;
    step();
    n_checks++; if (o_req !== 1'b0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rdp_redirect_cycle got req=%0b valid=%0b expected req=0 valid=1", o_req, o_valid); end
    redirect_valid = 1'b0;
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_flushed got valid=%0b pc=%0d expected valid=0", o_valid, o_pc); end
    n_checks++; if (o_req !== 1'b1 || o_addr !== 6'd20) begin n_fail++; $display("FAIL rdp_target_addr got req=%0b addr=%0d expected req=1 addr=20", o_req, o_addr); end
    step();
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_gap got valid=%0b expected 0", o_valid); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd20) begin n_fail++; $display("FAIL rdp_first got valid=%0b pc=%0d expected valid=1 pc=20", o_valid, o_pc); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd21) begin n_fail++; $display("FAIL rdp_second got valid=%0b pc=%0d expected valid=1 pc=21", o_valid, o_pc); end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_addr [3];
    logic [5:0] exp_pc [4];
    exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0;
    exp_pc[0] = 6'd62; exp_pc[1] = 6'd63; exp_pc[2] = 6'd0; exp_pc[3] = 6'd1;
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_target = 6'd62;
    step();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req_in_redirect got %0b expected 0", o_req); end
    redirect_valid = 1'b0;
    for (int n = 1; n < 7; n++) begin
      step();
      if (n <= 3) begin
        n_checks++; if (o_addr !== exp_addr[n-1]) begin n_fail++; $display("FAIL wrap_addr cyc=%0d got %0d expected %0d", n, o_addr, exp_addr[n-1]); end
      end
      if (n >= 3) begin
        n_checks++; if (o_valid !== 1'b1 || o_pc !== exp_pc[n-3]) begin n_fail++; $display("FAIL wrap_pc cyc=%0d got valid=%0b pc=%0d expected valid=1 pc=%0d", n, o_valid, o_pc, exp_pc[n-3]); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    bus.imem_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      n_checks++; if (o_req !== 1'b1 || o_addr !== 6'd0) begin n_fail++; $display("FAIL stall_hold cyc=%0d got req=%0b addr=%0d expected req=1 addr=0", n, o_req, o_addr); end
    end
    bus.imem_ready = 1'b1;
    for (int n = 5; n < 10; n++) begin
      step();
      n_checks++; if (o_addr !== 6'(n - 5)) begin n_fail++; $display("FAIL stall_addr cyc=%0d got %0d expected %0d", n, o_addr, n - 5); end
      if (n >= 7) begin
        n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'(n - 7)) begin n_fail++; $display("FAIL stall_pc cyc=%0d got valid=%0b pc=%0d expected valid=1 pc=%0d", n, o_valid, o_pc, n - 7); end
      end
    end
    bus.imem_ready = 1'b0;
    for (int n = 10; n < 13; n++) begin
      step();
      n_checks++; if (o_addr !== 6'd5) begin n_fail++; $display("FAIL stall2_hold cyc=%0d got %0d expected 5", n, o_addr); end
    end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stall2_drained got %0b expected 0", o_valid); end
    bus.imem_ready = 1'b1;
    step();
    n_checks++; if (o_addr !== 6'd5) begin n_fail++; $display("FAIL stall2_resume got %0d expected 5", o_addr); end
    step();
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd5) begin n_fail++; $display("FAIL stall2_pc5 got valid=%0b pc=%0d expected valid=1 pc=5", o_valid, o_pc); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 6'd6) begin n_fail++; $display("FAIL stall2_pc6 got valid=%0b pc=%0d expected valid=1 pc=6", o_valid, o_pc); end
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 6'd0;
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.ins_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_wrap();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
